version_slot_ctrl: RTL
======================

# version_slot_ctrl

Controller for a four-entry multi-version value store. Accepts writes through a valid/ready port, stamps each write with a monotonically increasing version number, and overwrites the oldest slot. Serves version-qualified reads by scanning the slots sequentially and returning the newest entry whose version is strictly below the requested read version. Sits between requesters and the slot storage, and arbitrates one shared slot bank between the write and read streams.

## Interface
- `BLOCK_SIZE`, 4: version number width.
- `DATA_WIDTH`, 32: data word width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `flush` in 1: synchronous clear of all slots and of the version counter.
- `wr_valid` in 1: write request.
- `wr_ready` out 1: write accepted when `wr_valid && wr_ready`.
- `wr_data` in DATA_WIDTH: write payload.
- `wr_version` out BLOCK_SIZE: version assigned to the most recently accepted write (registered).
- `rd_valid` in 1: read request.
- `rd_ready` out 1: read accepted when `rd_valid && rd_ready`.
- `rd_version` in BLOCK_SIZE: read version; entries with version < `rd_version` are eligible.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: response consumed when `rsp_valid && rsp_ready`.
- `rsp_hit` out 1: an eligible entry was found.
- `rsp_data` out DATA_WIDTH: data of the selected entry; 0 on a miss.
- `rsp_version` out BLOCK_SIZE: version of the selected entry; 0 on a miss.

## Operation
- **State:**
  - 4 slots, each holding `{valid, version, data}`.
  - `wr_ptr` (2 bits).
  - `next_ver` counter.
  - `last_grant` flag (write/read).
  - FSM states: IDLE, SCAN, RESP.
- **IDLE:**
  - A write is eligible when `wr_valid` is high and `next_ver` is not saturated.
  - A read is eligible when `rd_valid` is high.
  - When exactly one request is eligible, it is granted.
  - When both are eligible, the request type that did not win the last transfer is granted.
  - `last_grant` updates only on an actual transfer.
  - `wr_ready` and `rd_ready` are high only for the granted side, and only in IDLE.
- **Write transfer** (completes in IDLE, one cycle):
  - slot[`wr_ptr`] ← `{1, next_ver, wr_data}`.
  - `wr_version` ← `next_ver`.
  - `next_ver` increments.
  - `wr_ptr` increments mod 4.
  - Because versions are issued in order, `wr_ptr` always points at an empty or oldest slot.
- **Version saturation:**
  - Versions start at 1.
  - Once `next_ver` = 2^BLOCK_SIZE−1 has been issued, the counter stays at that value and `wr_ready` is held low until `flush`.
  - Versions never wrap.
- **Read transfer:** latch `rd_version`, clear the best-candidate register, go to SCAN.
- **SCAN:**
  - One slot per cycle, slot 0 to slot 3.
  - Slot i replaces the candidate when it is valid, its version < the latched `rd_version`, and (no candidate yet, or its version > the candidate version).
  - After slot 3, go to RESP.
- **RESP:**
  - Drive `rsp_valid`, `rsp_hit`, `rsp_data`, `rsp_version` from the candidate.
  - Hold them stable until `rsp_ready`, then return to IDLE.
- **Flush** (any state; highest priority):
  - All slot valid bits cleared, `wr_ptr`=0, `next_ver`=1, `wr_version`=0.
  - FSM goes to IDLE and any pending response is dropped.
  - `wr_ready` and `rd_ready` are low in the flush cycle.
- **Reset values:**
  - `wr_ready`, `rd_ready`, `rsp_valid`, `rsp_hit` = 0.
  - `rsp_data`, `rsp_version`, `wr_version` = 0.
  - All slots invalid, `next_ver`=1, `wr_ptr`=0.
  - `last_grant` = read, so the first contended cycle grants the write.
  - FSM = IDLE.
- **Reset mid-scan:** the read is lost and no response is issued.

## Timing
- **Write:**
  - Accepted at edge E.
  - Slot contents and `wr_version` are visible after E.
  - A read granted at E+1 observes that write.
- **Read latency:**
  - Accepted at edge E.
  - Scan occupies cycles E+1 to E+4.
  - `rsp_valid` is high from the cycle after edge E+4, i.e. 5 cycles after acceptance, and stays high until `rsp_ready`.
- **Throughput:**
  - Back-to-back reads: one per 5 cycles plus response wait.
  - Back-to-back writes: one per cycle.
- **No writes during SCAN or RESP**, so every read sees a consistent snapshot.
- Ready outputs are combinational from state, the valids, and the saturation flag. There is no combinational path from `rsp_ready` to any output.

## Structure
- **Package `version_store_pkg`:**
  - FSM state typedef (IDLE, SCAN, RESP).
  - `NUM_SLOTS`=4.
  - `VERSION_INIT`=1.
  - Slot record typedef `{valid, version, data}`.
- **Sub-module `version_slot_bank`:**
  - 4-entry slot register file.
  - Indexed write port and indexed read port.
  - Asynchronous active-low clear of the valid bits plus a synchronous clear input.
- The controller holds the FSM, arbiter, counter and candidate registers.

## Test plan
- **Fill and hit:** write 0xA0, 0xA1, 0xA2 (versions 1, 2, 3), then read with `rd_version`=3 → `rsp_hit`=1, `rsp_version`=2, `rsp_data`=0xA1, `rsp_valid` 5 cycles after acceptance.
- **Miss and eviction:**
  - Read `rd_version`=1 on the filled store → `rsp_hit`=0, data 0, version 0.
  - Write 5 words, then read `rd_version`=15 → version 5, and slot 0 holds version 5.
- **Contention:**
  - Hold `wr_valid` and `rd_valid` high from reset → grants alternate write, read, write, …, starting with the write.
  - No write is accepted while a read is in SCAN or RESP.
- **Saturation:**
  - Issue 15 writes → `wr_version`=15 and `wr_ready` stays low.
  - `flush` → next write is assigned version 1.
- **Response backpressure:** hold `rsp_ready` low for 10 cycles → outputs stable and `rd_ready` low throughout; a single `rsp_ready` pulse returns the FSM to IDLE.
- **Reset/flush mid-scan:**
  - Assert `rst_n`=0 in scan cycle 2 → all outputs at reset values immediately, and no response is produced afterwards.
  - Repeat with `flush` → same result, and a following read with `rd_version`=15 misses.

Source files
------------

// File: rtl/version_store_pkg.sv
// Shared types and constants for the multi-version slot store.
// Contents:
//   state_e        controller FSM states
//   grant_e        which request type won the last transfer
//   slot_t         one stored entry {valid, version, data}
//   beats_candidate  scan comparison used to pick the newest eligible entry
// The slot record is sized by VER_W / DATA_W. The controller's BLOCK_SIZE and
// DATA_WIDTH parameters must stay equal to these.
package version_store_pkg;

    localparam int NUM_SLOTS    = 4;
    localparam int SLOT_IDX_W   = 2;
    localparam int VERSION_INIT = 1;
    localparam int VER_W        = 4;
    localparam int DATA_W       = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic {
        GRANT_WR = 1'b0,
        GRANT_RD = 1'b1
    } grant_e;

    typedef struct packed {
        logic              valid;
        logic [VER_W-1:0]  version;
        logic [DATA_W-1:0] data;
    } slot_t;

    // A slot displaces the current candidate when it is valid, strictly older
    // than the read version, and newer than whatever was picked so far.
    function automatic logic beats_candidate(input slot_t            s,
                                             input logic [VER_W-1:0] limit,
                                             input logic             have,
                                             input logic [VER_W-1:0] best);
        return s.valid && (s.version < limit) && (!have || (s.version > best));
    endfunction

endpackage

// File: rtl/version_slot_ctrl_if.sv
// Request/response bundle between requesters and version_slot_ctrl.
// Signals:
//   wr_valid/wr_ready/wr_data     write request channel
//   wr_version                    version stamped on the last accepted write
//   rd_valid/rd_ready/rd_version  read request channel
//   rsp_valid/rsp_ready           response handshake
//   rsp_hit/rsp_data/rsp_version  response payload (zeros on a miss)
// Modports: master = requester side, slave = controller side.
interface version_slot_ctrl_if #(
    parameter int BLOCK_SIZE = 4,
    parameter int DATA_WIDTH = 32
) ();

    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [BLOCK_SIZE-1:0] wr_version;

    logic                  rd_valid;
    logic                  rd_ready;
    logic [BLOCK_SIZE-1:0] rd_version;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_hit;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic [BLOCK_SIZE-1:0] rsp_version;

    modport master (
        output wr_valid, wr_data, rd_valid, rd_version, rsp_ready,
        input  wr_ready, wr_version, rd_ready, rsp_valid, rsp_hit, rsp_data, rsp_version
    );

    modport slave (
        input  wr_valid, wr_data, rd_valid, rd_version, rsp_ready,
        output wr_ready, wr_version, rd_ready, rsp_valid, rsp_hit, rsp_data, rsp_version
    );

endinterface

// File: rtl/version_slot_bank.sv
// Four-entry slot register file.
// Ports:
//   clk, rst_n   clock; async active-low reset clears every slot
//   clr          synchronous clear of all valid bits (wins over a write)
//   we, wr_idx, wr_slot   indexed write port
//   rd_idx, rd_slot       indexed combinational read port
module version_slot_bank
    import version_store_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  we,
    input  logic [SLOT_IDX_W-1:0] wr_idx,
    input  slot_t                 wr_slot,
    input  logic [SLOT_IDX_W-1:0] rd_idx,
    output slot_t                 rd_slot
);

    slot_t slots_q [NUM_SLOTS];
    slot_t slots_d [NUM_SLOTS];

    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            slots_d[i] = slots_q[i];
            if (clr) begin
                slots_d[i].valid = 1'b0;
            end
        end
        if (we && !clr) begin
            slots_d[wr_idx] = wr_slot;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slots_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slots_q[i] <= slots_d[i];
            end
        end
    end

    assign rd_slot = slots_q[rd_idx];

endmodule

// File: rtl/version_slot_ctrl.sv
// Controller for a four-entry multi-version value store.
// Writes are stamped with an increasing version and overwrite the oldest slot.
// Reads scan all four slots (one per cycle) and return the newest entry whose
// version is strictly below the requested read version.
// Ports:
//   clk, rst_n   clock; async active-low reset
//   flush        synchronous clear of slots, version counter and pending read
//   bus          version_slot_ctrl_if slave modport (write, read, response)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | arbitrate write/read; a write completes here in one cycle
// SCAN  | visit slot scan_idx, update best candidate; slot 3 -> RESP
// RESP  | hold response outputs until rsp_ready
module version_slot_ctrl
    import version_store_pkg::*;
#(
    parameter int BLOCK_SIZE = VER_W,
    parameter int DATA_WIDTH = DATA_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    version_slot_ctrl_if.slave   bus
);

    localparam logic [BLOCK_SIZE-1:0] VER_MAX   = '1;
    localparam logic [BLOCK_SIZE-1:0] VER_FIRST = BLOCK_SIZE'(VERSION_INIT);

    state_e                 state_q,       state_d;
    grant_e                 last_grant_q,  last_grant_d;
    logic [SLOT_IDX_W-1:0]  wr_ptr_q,      wr_ptr_d;
    logic [BLOCK_SIZE-1:0]  next_ver_q,    next_ver_d;
    logic                   sat_q,         sat_d;
    logic [BLOCK_SIZE-1:0]  wr_version_q,  wr_version_d;
    logic [BLOCK_SIZE-1:0]  rd_ver_q,      rd_ver_d;
    logic [SLOT_IDX_W-1:0]  scan_idx_q,    scan_idx_d;
    logic                   cand_hit_q,    cand_hit_d;
    logic [BLOCK_SIZE-1:0]  cand_ver_q,    cand_ver_d;
    logic [DATA_WIDTH-1:0]  cand_data_q,   cand_data_d;
    logic                   rsp_valid_q,   rsp_valid_d;
    logic                   rsp_hit_q,     rsp_hit_d;
    logic [DATA_WIDTH-1:0]  rsp_data_q,    rsp_data_d;
    logic [BLOCK_SIZE-1:0]  rsp_version_q, rsp_version_d;

    logic  wr_elig;
    logic  rd_elig;
    logic  arb_open;
    logic  grant_wr;
    logic  grant_rd;
    logic  take;
    slot_t wr_slot;
    slot_t scan_slot;

    // Arbitration is combinational so a request can be accepted in the same
    // cycle it is raised; it never looks at rsp_ready.
    always_comb begin
        wr_elig  = bus.wr_valid && !sat_q;
        rd_elig  = bus.rd_valid;
        arb_open = (state_q == ST_IDLE) && !flush;
        grant_wr = arb_open && wr_elig && (!rd_elig || (last_grant_q == GRANT_RD));
        grant_rd = arb_open && rd_elig && (!wr_elig || (last_grant_q == GRANT_WR));
    end

    assign bus.wr_ready = grant_wr;
    assign bus.rd_ready = grant_rd;

    always_comb begin
        wr_slot         = '0;
        wr_slot.valid   = 1'b1;
        wr_slot.version = next_ver_q;
        wr_slot.data    = bus.wr_data;
    end

    version_slot_bank u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (flush),
        .we      (grant_wr),
        .wr_idx  (wr_ptr_q),
        .wr_slot (wr_slot),
        .rd_idx  (scan_idx_q),
        .rd_slot (scan_slot)
    );

    assign take = beats_candidate(scan_slot, rd_ver_q, cand_hit_q, cand_ver_q);

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        wr_ptr_d      = wr_ptr_q;
        next_ver_d    = next_ver_q;
        sat_d         = sat_q;
        wr_version_d  = wr_version_q;
        rd_ver_d      = rd_ver_q;
        scan_idx_d    = scan_idx_q;
        cand_hit_d    = cand_hit_q;
        cand_ver_d    = cand_ver_q;
        cand_data_d   = cand_data_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_hit_d     = rsp_hit_q;
        rsp_data_d    = rsp_data_q;
        rsp_version_d = rsp_version_q;

        if (flush) begin
            state_d       = ST_IDLE;
            wr_ptr_d      = '0;
            next_ver_d    = VER_FIRST;
            sat_d         = 1'b0;
            wr_version_d  = '0;
            scan_idx_d    = '0;
            cand_hit_d    = 1'b0;
            cand_ver_d    = '0;
            cand_data_d   = '0;
            rsp_valid_d   = 1'b0;
            rsp_hit_d     = 1'b0;
            rsp_data_d    = '0;
            rsp_version_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_wr) begin
                        last_grant_d = GRANT_WR;
                        wr_version_d = next_ver_q;
                        wr_ptr_d     = wr_ptr_q + 1'b1;
                        // The top version is issued once; afterwards the
                        // counter parks and writes stay blocked until flush.
                        if (next_ver_q == VER_MAX) begin
                            sat_d = 1'b1;
                        end else begin
                            next_ver_d = next_ver_q + 1'b1;
                        end
                    end else if (grant_rd) begin
                        last_grant_d = GRANT_RD;
                        rd_ver_d     = bus.rd_version;
                        scan_idx_d   = '0;
                        cand_hit_d   = 1'b0;
                        cand_ver_d   = '0;
                        cand_data_d  = '0;
                        state_d      = ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (take) begin
                        cand_hit_d  = 1'b1;
                        cand_ver_d  = scan_slot.version;
                        cand_data_d = scan_slot.data;
                    end
                    scan_idx_d = scan_idx_q + 1'b1;
                    if (scan_idx_q == SLOT_IDX_W'(NUM_SLOTS - 1)) begin
                        // Fold the last slot directly into the response so
                        // it is valid right after the fourth scan cycle.
                        state_d       = ST_RESP;
                        rsp_valid_d   = 1'b1;
                        rsp_hit_d     = take ? 1'b1 : cand_hit_q;
                        rsp_version_d = take ? scan_slot.version : cand_ver_q;
                        rsp_data_d    = take ? scan_slot.data : cand_data_q;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        state_d       = ST_IDLE;
                        rsp_valid_d   = 1'b0;
                        rsp_hit_d     = 1'b0;
                        rsp_data_d    = '0;
                        rsp_version_d = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            last_grant_q  <= GRANT_RD;
            wr_ptr_q      <= '0;
            next_ver_q    <= VER_FIRST;
            sat_q         <= 1'b0;
            wr_version_q  <= '0;
            rd_ver_q      <= '0;
            scan_idx_q    <= '0;
            cand_hit_q    <= 1'b0;
            cand_ver_q    <= '0;
            cand_data_q   <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_hit_q     <= 1'b0;
            rsp_data_q    <= '0;
            rsp_version_q <= '0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            wr_ptr_q      <= wr_ptr_d;
            next_ver_q    <= next_ver_d;
            sat_q         <= sat_d;
            wr_version_q  <= wr_version_d;
            rd_ver_q      <= rd_ver_d;
            scan_idx_q    <= scan_idx_d;
            cand_hit_q    <= cand_hit_d;
            cand_ver_q    <= cand_ver_d;
            cand_data_q   <= cand_data_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_hit_q     <= rsp_hit_d;
            rsp_data_q    <= rsp_data_d;
            rsp_version_q <= rsp_version_d;
        end
    end

    assign bus.wr_version  = wr_version_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_hit     = rsp_hit_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_version = rsp_version_q;

endmodule
